// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 pipeline.
//   icode_e : instruction codes seen by the fetch decoder
//   stat_e  : pipeline status codes carried with each instruction slot
//   fetch_state_e : encoding of the fetch sequencer FSM
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,  // fetching normally
        ST_WAIT_RET = 2'd1,  // ret fetched, bubbling until its target is known
        ST_HALTED   = 2'd2,  // halt fetched
        ST_FAULT    = 2'd3   // ADR or INS fetched
    } fetch_state_e;

endpackage

// File: rtl/y86_fetch_seq.sv
// y86_fetch_seq: fetch-stage sequencer for the pipelined Y86-64 core.
// Owns the PC that feeds the combinational fetch decoder, predicts the next
// PC, and handles stalls, mispredict redirects, ret bubbles, halt and faults.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   pc_o                current fetch PC (to the fetch decoder)
//   icode_i .. imem_error_i   decoder results for the instruction at pc_o
//   stall_i             hold F (load/use hazard)
//   mispredict_i, mis_pc_i    jXX resolved not-taken in E, with its fall-through
//   ret_done_i, ret_pc_i      ret reached W, with its return address
//   issue_o             instruction at pc_o enters D this cycle
//   stat_o              status of the issued slot (AOK when nothing issues)
//   state_o             FSM state
//   icnt_o              saturating count of issued instructions
module y86_fetch_seq
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [63:0]      pc_o,
    input  logic [3:0]       icode_i,
    input  logic [63:0]      valC_i,
    input  logic [63:0]      valP_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             stall_i,
    input  logic             mispredict_i,
    input  logic [63:0]      mis_pc_i,
    input  logic             ret_done_i,
    input  logic [63:0]      ret_pc_i,
    output logic             issue_o,
    output logic [2:0]       stat_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] icnt_o
);

    fetch_state_e     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             issue;
    stat_e            stat;
    logic [63:0]      pred_pc;

    // Gated by rst_n_i so nothing is reported as issued while reset is held.
    assign issue = rst_n_i && (state_q == ST_RUN) && !stall_i && !mispredict_i;

    // Jumps are predicted taken; calls always go to their target.
    assign pred_pc = ((icode_i == I_JXX) || (icode_i == I_CALL)) ? valC_i : valP_i;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        stat = STAT_AOK;
        if (issue) begin
            if (imem_error_i)          stat = STAT_ADR;
            else if (!instr_valid_i)   stat = STAT_INS;
            else if (icode_i == I_HALT) stat = STAT_HLT;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        icnt_d  = icnt_q;

        if (mispredict_i) begin
            // Squashes anything speculative, including halt/fault/ret.
            state_d = ST_RUN;
            pc_d    = mis_pc_i;
        end else if (ret_done_i && (state_q == ST_WAIT_RET)) begin
            state_d = ST_RUN;
            pc_d    = ret_pc_i;
        end else if (issue) begin
            if ((stat == STAT_ADR) || (stat == STAT_INS)) begin
                state_d = ST_FAULT;
            end else if (stat == STAT_HLT) begin
                state_d = ST_HALTED;
            end else if (icode_i == I_RET) begin
                state_d = ST_WAIT_RET;
            end else begin
                pc_d = pred_pc;
            end
        end
        // A stall in RUN deasserts issue, so the defaults already hold pc and state.

        if (issue && (icnt_q != {CNT_W{1'b1}})) begin
            icnt_d = icnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            icnt_q  <= icnt_d;
        end
    end

    assign pc_o    = pc_q;
    assign issue_o = issue;
    assign stat_o  = stat;
    assign state_o = state_q;
    assign icnt_o  = icnt_q;

endmodule

// File: doc/y86_fetch_seq.md
Name: y86_fetch_seq

Overview:
- Fetch-stage sequencer for the pipelined Y86-64 core.
- Owns the PC register that drives the combinational fetch decoder. Consumes that decoder's outputs: icode, valC, valP, instr_valid, imem_error.
- Predicts the next PC and applies stalls, branch-mispredict redirects and ret bubbles.
- Raises the halt and error status toward the pipeline control.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the issued-instruction counter; saturates at all-ones.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- pc_o  out  64  current fetch PC, driven from pc_q; goes to the fetch decoder
- icode_i  in  4  decoded icode at pc_o
- valC_i  in  64  decoded constant
- valP_i  in  64  fall-through address
- instr_valid_i  in  1  icode legal
- imem_error_i  in  1  PC out of instruction memory
- stall_i  in  1  hold F (load/use hazard)
- mispredict_i  in  1  jXX resolved not-taken in E
- mis_pc_i  in  64  correct fall-through PC for the mispredicted jXX
- ret_done_i  in  1  ret reached W
- ret_pc_i  in  64  return address from W
- issue_o  out  1  the instruction at pc_o is valid into D this cycle
- stat_o  out  3  status of the issued slot: 1=AOK, 2=HLT, 3=ADR, 4=INS
- state_o  out  2  FSM state
- icnt_o  out  CNT_W  issued-instruction count

Behaviour:
- Reset (async, rst_n_i low):
  - pc_q=RESET_PC
  - state=RUN
  - icnt=0
  - issue_o=0 and stat_o=AOK while in reset
- Interface: clock clk_i; reset rst_n_i, asynchronous, active-low.
- States:
  - RUN=0: fetching
  - WAIT_RET=1: ret fetched, bubbles until its target is known
  - HALTED=2: halt fetched
  - FAULT=3: ADR or INS fetched
- Combinational outputs:
  - issue_o = (state==RUN) & ~stall_i & ~mispredict_i
  - stat_o, when issue_o is high (priority order):
    - ADR if imem_error_i
    - else INS if ~instr_valid_i
    - else HLT if icode_i==0
    - else AOK
  - stat_o=AOK when issue_o is low.
- Next-PC prediction on issue:
  - valC_i for jXX (icode 7) and call (icode 8)
  - valP_i otherwise (jumps predicted taken)
- Priority per clock edge (first match wins):
  1. mispredict_i, any state: pc_q<=mis_pc_i, state<=RUN. This squashes speculative halt/fault/ret too.
  2. ret_done_i while in WAIT_RET: pc_q<=ret_pc_i, state<=RUN.
  3. stall_i in RUN: pc_q and state hold.
  4. issue_o:
     - stat_o==ADR or INS: state<=FAULT, pc_q holds
     - stat_o==HLT: state<=HALTED, pc_q holds
     - icode_i==9 (ret): state<=WAIT_RET, pc_q holds
     - otherwise: pc_q<=predicted PC
  5. Otherwise hold.
- ret_done_i outside WAIT_RET is ignored.
- HALTED and FAULT are left only by mispredict_i or reset.
- icnt increments by 1 on every issue_o cycle and saturates at 2^CNT_W-1.
- Latency: pc_o reflects a redirect or prediction one cycle after the deciding edge.
- Width/arithmetic:
  - PC is 64 bits; no range check inside this block.
  - Out-of-range PCs are reported through imem_error_i.
- Reset asserted mid-operation forces the reset state immediately, with no dependence on clk_i.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B
  - stat codes: AOK=1, HLT=2, ADR=3, INS=4
  - FSM state encoding
- No sub-module; the predict mux stays inline. The fetch decoder remains a separate instance in the F stage.

Test Plan:
- Reset then release:
  - nop at 0 (valP=1) → cycle 1: pc_o=0, issue_o=1, stat_o=AOK
  - next cycle: pc_o=1, icnt_o=1
- jXX at 0x10, valC=0x80, valP=0x19:
  - → pc_o=0x80 next cycle
  - mispredict_i=1 with mis_pc_i=0x19, asserted together with stall_i=1 → pc_o=0x19, state_o=RUN, issue_o=0 that cycle
- ret at 0x20:
  - → state_o=WAIT_RET, issue_o=0 for 3 cycles
  - ret_done_i=1, ret_pc_i=0x44 → pc_o=0x44, RUN
  - ret_done_i pulsed in RUN → no effect
- halt at 0x30 → stat_o=HLT for one cycle, then HALTED with issue_o=0 and pc_o frozen at 0x30. A later mispredict_i with mis_pc_i=0x2A → RUN, pc_o=0x2A.
- Faults:
  - imem_error_i=1 → stat_o=ADR, state_o=FAULT
  - icode 0xD (instr_valid_i=0) → stat_o=INS, state_o=FAULT
- Stall then reset:
  - stall_i=1 for 2 cycles → pc_o and icnt_o unchanged
  - rst_n_i low mid-cycle → pc_o=RESET_PC asynchronously
